multifilter_row_pe: RTL and testbench

//  Next-gen row-stationary PE: 1-D convolution of one ifmap row against up to MAX_FILTERS filter rows, one shared MAC.

---
 rtl/pe_pkg.sv | 19 +
 rtl/pe_mac_pipe.sv | 61 ++++++
 rtl/multifilter_row_pe.sv | 233 +++++++++++++++++++++++
 tb/tb_multifilter_row_pe.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and defaults for the row-stationary multi-filter PE.
// Holds the FSM state type, default scratchpad limits and width helpers.
package pe_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE
  } state_e;

  localparam int IFMAP_SPAD_DEPTH_D  = 12;
  localparam int FILTER_SPAD_DEPTH_D = 224;
  localparam int MAX_FILTERS_D       = 16;

  function automatic int nf_width(input int max_f);
    return $clog2(max_f) + 1;
  endfunction

endpackage

// File: rtl/pe_mac_pipe.sv
// Two-stage signed MAC: operand register, then multiply-accumulate.
// A first-tap operand selects the seed instead of the running sum.
module pe_mac_pipe #(
  parameter int IW = 16,
  parameter int FW = 16,
  parameter int AW = 40
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          stall_i,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [IW-1:0] a_i,
  input  logic [FW-1:0] b_i,
  input  logic          first_i,
  input  logic          last_i,
  input  logic [AW-1:0] seed_i,
  output logic          s1_valid_o,
  output logic          s1_first_o,
  output logic          res_fire_o,
  output logic [AW-1:0] res_o
);

  logic signed [IW-1:0]    a_q;
  logic signed [FW-1:0]    b_q;
  logic                    v_q;
  logic                    first_q;
  logic                    last_q;
  logic [AW-1:0]           acc_q;
  logic signed [IW+FW-1:0] prod;
  logic [AW-1:0]           prod_x;

  assign prod   = a_q * b_q;
  assign prod_x = AW'(prod);
  assign res_o  = (first_q ? seed_i : acc_q) + prod_x;

  assign s1_valid_o = v_q;
  assign s1_first_o = first_q;
  assign res_fire_o = v_q & last_q & ~stall_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      acc_q   <= '0;
    end else if (clear_i) begin
      v_q <= 1'b0;
    end else if (!stall_i) begin
      v_q     <= valid_i;
      a_q     <= a_i;
      b_q     <= b_i;
      first_q <= first_i;
      last_q  <= last_i;
      if (v_q) acc_q <= res_o;
    end
  end

endmodule

// File: rtl/multifilter_row_pe.sv
// Row-stationary PE: one ifmap row against up to MAX_FILTERS filter rows.
// Define PE_PSUM_CHAIN_EN to seed each psum from the psum_in stream.
module multifilter_row_pe
  import pe_pkg::*;
#(
  parameter int CONFIG_BIT        = 5,
  parameter int IFMAP_DATA_WIDTH  = 16,
  parameter int FILTER_DATA_WIDTH = 16,
  parameter int IFMAP_SPAD_DEPTH  = IFMAP_SPAD_DEPTH_D,
  parameter int FILTER_SPAD_DEPTH = FILTER_SPAD_DEPTH_D,
  parameter int MAX_FILTERS       = MAX_FILTERS_D,
  parameter int ACC_WIDTH         = 40
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           en,
  input  logic                           start,
  input  logic [CONFIG_BIT-1:0]          cfg_ifmap_size,
  input  logic [CONFIG_BIT-1:0]          cfg_filter_size,
  input  logic [CONFIG_BIT-1:0]          cfg_stride,
  input  logic [nf_width(MAX_FILTERS)-1:0] cfg_num_filters,
  input  logic                           ifmap_valid,
  output logic                           ifmap_ready,
  input  logic [IFMAP_DATA_WIDTH-1:0]    ifmap_din,
  input  logic                           filter_valid,
  output logic                           filter_ready,
  input  logic [FILTER_DATA_WIDTH-1:0]   filter_din,
  output logic                           psum_out_valid,
  input  logic                           psum_out_ready,
  output logic [ACC_WIDTH-1:0]           psum_out_data,
`ifdef PE_PSUM_CHAIN_EN
  input  logic                           psum_in_valid,
  output logic                           psum_in_ready,
  input  logic [ACC_WIDTH-1:0]           psum_in_data,
`endif
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err
);

  localparam int NFW = nf_width(MAX_FILTERS);
  localparam int CW  = CONFIG_BIT;
  localparam int WW  = CW + 2;
  localparam int IAW = $clog2(IFMAP_SPAD_DEPTH);
  localparam int FAW = $clog2(FILTER_SPAD_DEPTH);
  localparam int TW  = FAW + 1;

  state_e state_q, state_d;

  logic [CW-1:0]  is_q, fs_q, s_q;
  logic [NFW-1:0] nf_q;
  logic [TW-1:0]  tot_q;
  logic [CW-1:0]  ic_q;
  logic [TW-1:0]  fc_q;
  logic [CW-1:0]  base_q, k_q;
  logic [NFW-1:0] f_q;
  logic [FAW-1:0] fbase_q;
  logic           iss_done_q;
  logic           out_full_q;
  logic [ACC_WIDTH-1:0] out_q;
  logic           done_q, cfg_err_q;

  logic signed [IFMAP_DATA_WIDTH-1:0]  ifmap_spad  [IFMAP_SPAD_DEPTH];
  logic signed [FILTER_DATA_WIDTH-1:0] filter_spad [FILTER_SPAD_DEPTH];

  logic [31:0] c_is, c_fs, c_s, c_nf, c_tot;
  logic        cfg_bad, idle, start_ok;
  logic        ld_done, ifire, ffire;
  logic        out_block, chain_wait, stall, issue;
  logic        last_tap, last_f, win_more;
  logic [WW-1:0]  nxt_base;
  logic [IAW-1:0] ia;
  logic [FAW-1:0] fa;
  logic [ACC_WIDTH-1:0] seed, res;
  logic        seed_valid, s1_v, s1_first, res_fire, drain, finish;

  assign c_is  = 32'(cfg_ifmap_size);
  assign c_fs  = 32'(cfg_filter_size);
  assign c_s   = 32'(cfg_stride);
  assign c_nf  = 32'(cfg_num_filters);
  assign c_tot = c_nf * c_fs;

  assign cfg_bad = (c_is == 0) || (c_fs == 0) || (c_s == 0) ||
                   (c_nf == 0) || (c_fs > c_is) ||
                   (c_is > IFMAP_SPAD_DEPTH) ||
                   (c_nf > MAX_FILTERS) ||
                   (c_tot > FILTER_SPAD_DEPTH);

  assign idle     = (state_q == S_IDLE);
  assign start_ok = en & start & idle & ~cfg_bad;

  assign ld_done      = (ic_q == is_q) && (fc_q == tot_q);
  assign ifmap_ready  = en & (state_q == S_LOAD) & (ic_q != is_q);
  assign filter_ready = en & (state_q == S_LOAD) & (fc_q != tot_q);
  assign ifire        = ifmap_ready & ifmap_valid;
  assign ffire        = filter_ready & filter_valid;

`ifdef PE_PSUM_CHAIN_EN
  assign seed_valid    = psum_in_valid;
  assign seed          = psum_in_data;
  assign psum_in_ready = en & ~out_block & s1_v & s1_first;
`else
  assign seed_valid = 1'b1;
  assign seed       = '0;
`endif

  // The whole MAC pipe freezes as one so no tap overtakes a blocked psum.
  assign psum_out_valid = en & out_full_q;
  assign out_block  = out_full_q & ~psum_out_ready;
  assign chain_wait = s1_v & s1_first & ~seed_valid;
  assign stall      = ~en | out_block | chain_wait;
  assign issue      = (state_q == S_COMPUTE) & ~iss_done_q & ~stall;
  assign drain      = psum_out_valid & psum_out_ready;

  assign last_tap = (k_q == fs_q - CW'(1));
  assign last_f   = (f_q == nf_q - NFW'(1));
  assign nxt_base = WW'(base_q) + WW'(s_q);
  assign win_more = (nxt_base + WW'(fs_q)) <= WW'(is_q);

  assign ia = IAW'(base_q) + IAW'(k_q);
  assign fa = fbase_q + FAW'(k_q);

  assign finish = (state_q == S_COMPUTE) & iss_done_q & ~s1_v & drain;

  assign psum_out_data = out_q;
  assign busy          = ~idle;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

  pe_mac_pipe #(
    .IW(IFMAP_DATA_WIDTH),
    .FW(FILTER_DATA_WIDTH),
    .AW(ACC_WIDTH)
  ) u_mac (
    .clk        (clk),
    .rstn       (rstn),
    .stall_i    (stall),
    .clear_i    (start_ok),
    .valid_i    (issue),
    .a_i        (ifmap_spad[ia]),
    .b_i        (filter_spad[fa]),
    .first_i    (k_q == '0),
    .last_i     (last_tap),
    .seed_i     (seed),
    .s1_valid_o (s1_v),
    .s1_first_o (s1_first),
    .res_fire_o (res_fire),
    .res_o      (res)
  );

  always_ff @(posedge clk) begin
    if (ifire) ifmap_spad[ic_q[IAW-1:0]] <= ifmap_din;
    if (ffire) filter_spad[fc_q[FAW-1:0]] <= filter_din;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_ok) state_d = S_LOAD;
      S_LOAD:    if (en && ld_done) state_d = S_COMPUTE;
      S_COMPUTE: if (finish) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      is_q       <= '0;
      fs_q       <= '0;
      s_q        <= '0;
      nf_q       <= '0;
      tot_q      <= '0;
      ic_q       <= '0;
      fc_q       <= '0;
      base_q     <= '0;
      k_q        <= '0;
      f_q        <= '0;
      fbase_q    <= '0;
      iss_done_q <= 1'b0;
      out_full_q <= 1'b0;
      out_q      <= '0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= finish;
      cfg_err_q <= en & start & idle & cfg_bad;
      if (start_ok) begin
        is_q  <= cfg_ifmap_size;
        fs_q  <= cfg_filter_size;
        s_q   <= cfg_stride;
        nf_q  <= cfg_num_filters;
        tot_q <= TW'(c_tot);
        ic_q  <= '0;
        fc_q  <= '0;
      end
      if (ifire) ic_q <= ic_q + 1'b1;
      if (ffire) fc_q <= fc_q + 1'b1;
      if (en && state_q == S_LOAD && ld_done) begin
        base_q     <= '0;
        k_q        <= '0;
        f_q        <= '0;
        fbase_q    <= '0;
        iss_done_q <= 1'b0;
      end
      // Filter row base advances by a running add of the tap count.
      if (issue) begin
        if (!last_tap) begin
          k_q <= k_q + 1'b1;
        end else begin
          k_q <= '0;
          if (!last_f) begin
            f_q     <= f_q + 1'b1;
            fbase_q <= fbase_q + FAW'(fs_q);
          end else begin
            f_q     <= '0;
            fbase_q <= '0;
            if (win_more) base_q <= nxt_base[CW-1:0];
            else          iss_done_q <= 1'b1;
          end
        end
      end
      if (res_fire) begin
        out_q      <= res;
        out_full_q <= 1'b1;
      end else if (drain) begin
        out_full_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multifilter_row_pe.sv
// Directed self-checking bench for multifilter_row_pe.
// Define PE_PSUM_CHAIN_EN to also exercise psum chaining.
module tb_multifilter_row_pe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  cfg_ifmap_size = '0;
  logic [4:0]  cfg_filter_size = '0;
  logic [4:0]  cfg_stride = '0;
  logic [4:0]  cfg_num_filters = '0;
  logic        ifmap_valid = 1'b0;
  logic        ifmap_ready;
  logic [15:0] ifmap_din = '0;
  logic        filter_valid = 1'b0;
  logic        filter_ready;
  logic [15:0] filter_din = '0;
  logic        psum_out_valid;
  logic        psum_out_ready = 1'b1;
  logic [39:0] psum_out_data;
`ifdef PE_PSUM_CHAIN_EN
  logic        psum_in_valid = 1'b0;
  logic        psum_in_ready;
  logic [39:0] psum_in_data = '0;
`endif
  logic        busy, done, cfg_err;

  int checks = 0;
  int failures = 0;
  int ifq[$];
  int flq[$];
  int expq[$];

  always #5 clk = ~clk;

  multifilter_row_pe dut (
    .clk             (clk),
    .rstn            (rstn),
    .en              (en),
    .start           (start),
    .cfg_ifmap_size  (cfg_ifmap_size),
    .cfg_filter_size (cfg_filter_size),
    .cfg_stride      (cfg_stride),
    .cfg_num_filters (cfg_num_filters),
    .ifmap_valid     (ifmap_valid),
    .ifmap_ready     (ifmap_ready),
    .ifmap_din       (ifmap_din),
    .filter_valid    (filter_valid),
    .filter_ready    (filter_ready),
    .filter_din      (filter_din),
    .psum_out_valid  (psum_out_valid),
    .psum_out_ready  (psum_out_ready),
    .psum_out_data   (psum_out_data),
`ifdef PE_PSUM_CHAIN_EN
    .psum_in_valid   (psum_in_valid),
    .psum_in_ready   (psum_in_ready),
    .psum_in_data    (psum_in_data),
`endif
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err)
  );

  task automatic start_pass(input int is, input int fs, input int s, input int nf);
    @(negedge clk);
    cfg_ifmap_size  = 5'(is);
    cfg_filter_size = 5'(fs);
    cfg_stride      = 5'(s);
    cfg_num_filters = 5'(nf);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_rows();
    for (int i = 0; i < ifq.size(); i++) begin
      int n;
      n = 0;
      ifmap_valid = 1'b1;
      ifmap_din = 16'(ifq[i]);
      while (!ifmap_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!ifmap_ready) begin
        checks++;
        failures++;
        $display("FAIL load_ifmap word %0d: ready=0 required=1", i);
        ifmap_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    ifmap_valid = 1'b0;
    for (int i = 0; i < flq.size(); i++) begin
      int n;
      n = 0;
      filter_valid = 1'b1;
      filter_din = 16'(flq[i]);
      while (!filter_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!filter_ready) begin
        checks++;
        failures++;
        $display("FAIL load_filter word %0d: ready=0 required=1", i);
        filter_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    filter_valid = 1'b0;
  endtask

  task automatic collect(input string nm);
    for (int i = 0; i < expq.size(); i++) begin
      int n;
      n = 0;
      while (!psum_out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (!psum_out_valid) begin
        failures++;
        $display("FAIL %s psum%0d timeout: valid=0 required=1", nm, i);
        return;
      end
      if (psum_out_data !== 40'(expq[i])) begin
        failures++;
        $display("FAIL %s psum%0d: got %0d required %0d",
                 nm, i, $signed(psum_out_data), expq[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done: done=%b busy=%b required done=1 busy=0",
               nm, done, busy);
    end
  endtask

  task automatic set_case1();
    ifq  = '{1, 2, 3, 4, 5};
    flq  = '{1, 1, 1};
    expq = '{6, 9, 12};
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, cfg_err, ifmap_ready, filter_ready, psum_out_valid} !== 6'b0 ||
        psum_out_data !== 40'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b/%0h required 0",
               {busy, done, cfg_err, ifmap_ready, filter_ready, psum_out_valid},
               psum_out_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_case1();
    set_case1();
    start_pass(5, 3, 1, 1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL case1_busy: busy=%b required 1", busy);
    end
    load_rows();
    collect("case1");
  endtask

  task automatic test_stride_multi();
    ifq  = '{1, 2, 3, 4, 5, 6, 7};
    flq  = '{1, 0, -1, 2, 2, 2};
    expq = '{-2, 12, -2, 24, -2, 36};
    start_pass(7, 3, 2, 2);
    load_rows();
    collect("case2");
  endtask

  task automatic test_boundary();
    ifq = '{};
    flq = '{};
    for (int i = 1; i <= 12; i++) ifq.push_back(i);
    for (int i = 0; i < 12; i++) flq.push_back(1);
    for (int i = 0; i < 12; i++) flq.push_back(-1);
    expq = '{78, -78};
    start_pass(12, 12, 5, 2);
    load_rows();
    collect("full_spad");
  endtask

  task automatic test_backpressure();
    int n;
    logic held_bad;
    set_case1();
    psum_out_ready = 1'b0;
    start_pass(5, 3, 1, 1);
    load_rows();
    n = 0;
    while (!psum_out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!psum_out_valid || psum_out_data !== 40'd6) begin
      failures++;
      $display("FAIL bp_first: valid=%b data=%0d required valid=1 data=6",
               psum_out_valid, psum_out_data);
    end
    held_bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (psum_out_valid !== 1'b1 || psum_out_data !== 40'd6) held_bad = 1'b1;
    end
    checks++;
    if (held_bad) begin
      failures++;
      $display("FAIL bp_hold: last valid=%b data=%0d required valid=1 data=6",
               psum_out_valid, psum_out_data);
    end
    psum_out_ready = 1'b1;
    @(negedge clk);
    expq = '{9, 12};
    collect("bp_rest");
  endtask

  task automatic test_cfg_err();
    int tbl[3][4];
    tbl[0] = '{5, 6, 1, 1};
    tbl[1] = '{5, 3, 1, 0};
    tbl[2] = '{13, 3, 1, 1};
    for (int t = 0; t < 3; t++) begin
      start_pass(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3]);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 ||
          ifmap_ready !== 1'b0 || filter_ready !== 1'b0) begin
        failures++;
        $display("FAIL cfg_err%0d: err=%b busy=%b ir=%b fr=%b required 1,0,0,0",
                 t, cfg_err, busy, ifmap_ready, filter_ready);
      end
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL cfg_err_pulse%0d: err=%b busy=%b required 0,0",
                 t, cfg_err, busy);
      end
    end
  endtask

  task automatic test_en_freeze();
    logic bad;
    set_case1();
    start_pass(5, 3, 1, 1);
    load_rows();
    repeat (3) @(negedge clk);
    en = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (psum_out_valid !== 1'b0 || ifmap_ready !== 1'b0 ||
          filter_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL en_freeze: valid=%b busy=%b required valid=0 busy=1",
               psum_out_valid, busy);
    end
    en = 1'b1;
    collect("en_resume");
  endtask

  task automatic test_reset_midpass();
    ifq = '{1, 2, 3, 4, 5, 6, 7};
    flq = '{1, 0, -1, 2, 2, 2};
    start_pass(7, 3, 2, 2);
    load_rows();
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, cfg_err, ifmap_ready, filter_ready, psum_out_valid} !== 6'b0 ||
        psum_out_data !== 40'd0) begin
      failures++;
      $display("FAIL midpass_reset: got %b/%0h required 0",
               {busy, done, cfg_err, ifmap_ready, filter_ready, psum_out_valid},
               psum_out_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    set_case1();
    start_pass(5, 3, 1, 1);
    load_rows();
    collect("after_reset");
  endtask

  task automatic test_back_to_back();
    test_case1();
    test_stride_multi();
  endtask

`ifdef PE_PSUM_CHAIN_EN
  task automatic test_chain();
    logic bad;
    set_case1();
    psum_in_data  = 40'd100;
    psum_in_valid = 1'b1;
    expq = '{106, 109, 112};
    start_pass(5, 3, 1, 1);
    load_rows();
    collect("chain");
    psum_in_valid = 1'b0;
    start_pass(5, 3, 1, 1);
    load_rows();
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (psum_out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL chain_withheld: valid=1 required 0");
    end
    psum_in_valid = 1'b1;
    collect("chain_resume");
    psum_in_valid = 1'b0;
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_case1();
    test_stride_multi();
    test_boundary();
    test_backpressure();
    test_cfg_err();
    test_en_freeze();
    test_reset_midpass();
    test_back_to_back();
`ifdef PE_PSUM_CHAIN_EN
    test_chain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
